// File: rtl/otp_pkg.sv
// ---------------------------------------------------------------------------
// otp_pkg
// Shared definitions for the one-time-pad XOR scheduler.
//   KEY_SIZE    : default key word / chunk width in bits
//   MSG_SIZE    : default message width in bits
//   otp_state_t : scheduler FSM states (IDLE, RUN, DONE)
// ---------------------------------------------------------------------------
package otp_pkg;

    localparam int KEY_SIZE = 16;
    localparam int MSG_SIZE = 240;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } otp_state_t;

endpackage

// File: rtl/otp_rr_arbiter.sv
// ---------------------------------------------------------------------------
// otp_rr_arbiter
// Combinational round-robin arbiter. Picks the first valid requester at or
// after rr_ptr, wrapping around. The pointer itself is owned and advanced by
// the scheduler; this block only searches.
// Ports:
//   req_valid   in  N_REQ         per-requester valid
//   rr_ptr      in  $clog2(N_REQ) index with highest priority this cycle
//   grant       out N_REQ         one-hot grant (all zero if nothing valid)
//   grant_idx   out $clog2(N_REQ) index of the granted requester
//   grant_valid out 1             some requester was granted
// ---------------------------------------------------------------------------
module otp_rr_arbiter
    import otp_pkg::*;
#(
    parameter int N_REQ = 2,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    // Walk the requesters starting at rr_ptr and stop at the first valid
    // one. The grant_valid flag doubles as the "already found" marker so
    // later candidates in the walk cannot override an earlier winner.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int off = 0; off < N_REQ; off++) begin
            if (!grant_valid && req_valid[(int'(rr_ptr) + off) % N_REQ]) begin
                grant_valid                              = 1'b1;
                grant[(int'(rr_ptr) + off) % N_REQ]      = 1'b1;
                grant_idx = IDX_W'((int'(rr_ptr) + off) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/otp_cypher_sched.sv
// ---------------------------------------------------------------------------
// otp_cypher_sched
// Round-robin scheduler and sequencer for the one-time-pad XOR engine.
// A granted message is loaded into a shift register and XORed MSB-chunk
// first with one key word per beat; the reassembled cyphertext is then
// presented with the owning requester's index until the consumer accepts.
//
// Optional feature (macro OTP_KEY_USAGE_CNT_EN): adds output key_used, a
// saturating 32-bit count of consumed key words, cleared only by rst.
//
// Ports:
//   clk        in  1              clock, posedge
//   rst        in  1              asynchronous active-high reset
//   req_valid  in  N_REQ          per-requester message valid
//   req_msg    in  N_REQ*MSG_W    requester i at [i*MSG_W +: MSG_W]
//   req_ready  out N_REQ          one-hot accept pulse (IDLE only)
//   key_valid  in  1              key word available
//   key_data   in  KEY_W          key word
//   key_ready  out 1              high throughout RUN
//   out_valid  out 1              cyphertext valid (DONE)
//   out_data   out MSG_W          cyphertext
//   out_id     out $clog2(N_REQ)  owner of out_data
//   out_ready  in  1              consumer accepts
//   key_used   out 32             consumed key words (macro only)
//   busy       out 1              high in every state except IDLE
// ---------------------------------------------------------------------------
module otp_cypher_sched
    import otp_pkg::*;
#(
    parameter int MSG_W = MSG_SIZE,
    parameter int KEY_W = KEY_SIZE,
    parameter int N_REQ = 2,
    localparam int BEATS = MSG_W / KEY_W,
    localparam int ID_W  = $clog2(N_REQ),
    localparam int CNT_W = $clog2(BEATS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*MSG_W-1:0] req_msg,
    output logic [N_REQ-1:0]       req_ready,
    input  logic                   key_valid,
    input  logic [KEY_W-1:0]       key_data,
    output logic                   key_ready,
    output logic                   out_valid,
    output logic [MSG_W-1:0]       out_data,
    output logic [ID_W-1:0]        out_id,
    input  logic                   out_ready,
`ifdef OTP_KEY_USAGE_CNT_EN
    output logic [31:0]            key_used,
`endif
    output logic                   busy
);

    // A message that does not split into whole key words cannot be
    // sequenced; refuse to elaborate rather than silently truncate.
    if ((MSG_W % KEY_W) != 0) begin : g_width_check
        $error("otp_cypher_sched: MSG_W must be a multiple of KEY_W");
    end
    if (N_REQ < 2) begin : g_nreq_check
        $error("otp_cypher_sched: N_REQ must be at least 2");
    end

    otp_state_t         state;
    logic [MSG_W-1:0]   shreg;
    logic [MSG_W-1:0]   res;
    logic [CNT_W-1:0]   beat_cnt;
    logic [ID_W-1:0]    rr_ptr;
    logic [N_REQ-1:0]   grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_valid;
    logic [MSG_W-1:0]   sel_msg;
    logic [ID_W-1:0]    next_ptr;

    otp_rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req_valid   (req_valid),
        .rr_ptr      (rr_ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Message of the winning requester and the pointer value that gives
    // the next requester in line priority after this grant.
    always_comb begin
        sel_msg  = req_msg[int'(grant_idx)*MSG_W +: MSG_W];
        next_ptr = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end

    // Handshake outputs are pure decodes of the state register. Grants are
    // only offered while idle, so requests arriving during RUN/DONE wait.
    always_comb begin
        req_ready = (state == IDLE) ? grant : '0;
        key_ready = (state == RUN);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        out_data  = res;
    end

    // Main sequencer. IDLE captures the granted message, RUN consumes one
    // key word per beat shifting both the message and the result MSB-chunk
    // first, DONE holds the result until the consumer takes it. There is
    // no DONE-to-grant bypass: the next grant is at the earliest one cycle
    // after the output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            res      <= '0;
            beat_cnt <= '0;
            rr_ptr   <= '0;
            out_id   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        shreg    <= sel_msg;
                        out_id   <= grant_idx;
                        beat_cnt <= '0;
                        rr_ptr   <= next_ptr;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (key_valid) begin
                        res      <= {res[MSG_W-KEY_W-1:0],
                                     shreg[MSG_W-1 -: KEY_W] ^ key_data};
                        shreg    <= shreg << KEY_W;
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (beat_cnt == CNT_W'(BEATS - 1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef OTP_KEY_USAGE_CNT_EN
    logic [31:0] key_used_cnt;

    // Count every consumed key word so software can watch pad usage. The
    // counter sticks at all-ones instead of wrapping, so an exhausted pad
    // can never look fresh again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_used_cnt <= '0;
        end else if (key_valid && key_ready && (key_used_cnt != 32'hFFFF_FFFF)) begin
            key_used_cnt <= key_used_cnt + 32'd1;
        end
    end

    assign key_used = key_used_cnt;
`endif

endmodule

// File: tb/tb_otp_cypher_sched.sv
// ---------------------------------------------------------------------------
// tb_otp_cypher_sched
// Directed self-checking bench for otp_cypher_sched (default parameters).
// ---------------------------------------------------------------------------
module tb_otp_cypher_sched;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   req_valid = '0;
    logic [479:0] req_msg = '0;
    logic [1:0]   req_ready;
    logic         key_valid = 1'b0;
    logic [15:0]  key_data = '0;
    logic         key_ready;
    logic         out_valid;
    logic [239:0] out_data;
    logic [0:0]   out_id;
    logic         out_ready = 1'b0;
    logic         busy;
`ifdef OTP_KEY_USAGE_CNT_EN
    logic [31:0]  key_used;
`endif

    int total = 0;
    int bad   = 0;
    int key_mode = 0;

    localparam logic [239:0] MSG0 =
        240'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF_0123_4567_89AB_CDEF_4567_89AB_CDEF;
    localparam logic [239:0] MSG1 =
        240'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0_1357_9BDF_2468_ACE0_DEAD_BEEF_CAFE;

    otp_cypher_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_msg   (req_msg),
        .req_ready (req_ready),
        .key_valid (key_valid),
        .key_data  (key_data),
        .key_ready (key_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready),
`ifdef OTP_KEY_USAGE_CNT_EN
        .key_used  (key_used),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Expected cyphertext: chunk c (MSB first) XOR key word c.
    function automatic logic [239:0] model(input logic [239:0] m, input int mode);
        logic [239:0] r;
        logic [15:0]  k;
        r = m;
        for (int c = 0; c < 15; c++) begin
            k = (mode == 0) ? 16'hFFFF : 16'(c + 1);
            r[239-16*c -: 16] = m[239-16*c -: 16] ^ k;
        end
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        key_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives the key stream from the negedge of the grant cycle onward until
    // out_valid, an optional beat stop point, or a cycle budget runs out.
    task automatic pump(input logic [1:0] drop, input int stall_beat, input int stall_len,
                        input int stop_beat, output int ncyc, output bit kr_ok);
        int beat;
        int left;
        beat  = 0;
        left  = stall_len;
        ncyc  = 0;
        kr_ok = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            ncyc++;
            if (i == 0) req_valid = req_valid & ~drop;
            if (out_valid) begin
                key_valid = 1'b0;
                return;
            end
            if (stop_beat >= 0 && beat == stop_beat) begin
                key_valid = 1'b0;
                return;
            end
            if (!key_ready) kr_ok = 1'b0;
            if (beat == stall_beat && left > 0) begin
                key_valid = 1'b0;
                left--;
            end else begin
                key_valid = 1'b1;
                key_data  = (key_mode == 0) ? 16'hFFFF : 16'(beat + 1);
            end
            if (key_valid && key_ready) beat++;
        end
        ncyc = -1;
        key_valid = 1'b0;
    endtask

    task automatic finish_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        total++; if (req_ready !== 2'b00) begin bad++; $display("[TB] FAIL reset_req_ready got %b exp 00", req_ready); end
        total++; if (key_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_key_ready got %b exp 0", key_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got %b exp 0", out_valid); end
        total++; if (out_data !== 240'h0) begin bad++; $display("[TB] FAIL reset_out_data got %h exp 0", out_data); end
        total++; if (out_id !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_id got %b exp 0", out_id); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int n;
        bit ok;
        @(negedge clk);
        key_mode = 0;
        req_msg[0 +: 240] = MSG0;
        req_valid = 2'b01;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("[TB] FAIL single_grant got %b exp 01", req_ready); end
        pump(2'b01, -1, 0, -1, n, ok);
        total++; if (n !== 16) begin bad++; $display("[TB] FAIL single_latency got %0d exp 16", n); end
        total++; if (out_data !== ~MSG0) begin bad++; $display("[TB] FAIL single_data got %h exp %h", out_data, ~MSG0); end
        total++; if (out_id !== 1'b0) begin bad++; $display("[TB] FAIL single_id got %b exp 0", out_id); end
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL single_busy got %b exp 1", busy); end
        finish_out();
    endtask

    task automatic test_two_req();
        int n;
        bit ok;
        do_reset();
        key_mode = 1;
        req_msg[0 +: 240]   = MSG0;
        req_msg[240 +: 240] = MSG1;
        req_valid = 2'b11;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("[TB] FAIL two_first_grant got %b exp 01", req_ready); end
        pump(2'b01, -1, 0, -1, n, ok);
        total++; if (out_data !== model(MSG0, 1)) begin bad++; $display("[TB] FAIL two_data0 got %h exp %h", out_data, model(MSG0, 1)); end
        total++; if (out_id !== 1'b0) begin bad++; $display("[TB] FAIL two_id0 got %b exp 0", out_id); end
        total++; if (req_ready !== 2'b00) begin bad++; $display("[TB] FAIL two_no_grant_done got %b exp 00", req_ready); end
        finish_out();
        #1;
        total++; if (req_ready !== 2'b10) begin bad++; $display("[TB] FAIL two_second_grant got %b exp 10", req_ready); end
        pump(2'b10, -1, 0, -1, n, ok);
        total++; if (out_data !== model(MSG1, 1)) begin bad++; $display("[TB] FAIL two_data1 got %h exp %h", out_data, model(MSG1, 1)); end
        total++; if (out_id !== 1'b1) begin bad++; $display("[TB] FAIL two_id1 got %b exp 1", out_id); end
        finish_out();
    endtask

    task automatic test_key_stall();
        int n;
        bit ok;
        key_mode = 1;
        req_valid = 2'b01;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("[TB] FAIL stall_grant got %b exp 01", req_ready); end
        pump(2'b01, 7, 3, -1, n, ok);
        total++; if (n !== 19) begin bad++; $display("[TB] FAIL stall_latency got %0d exp 19", n); end
        total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL stall_key_ready got %b exp 1", ok); end
        total++; if (out_data !== model(MSG0, 1)) begin bad++; $display("[TB] FAIL stall_data got %h exp %h", out_data, model(MSG0, 1)); end
        finish_out();
    endtask

    task automatic test_out_hold();
        int n;
        bit ok;
        key_mode = 1;
        req_valid = 2'b01;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("[TB] FAIL hold_grant got %b exp 01", req_ready); end
        pump(2'b01, -1, 0, -1, n, ok);
        req_valid[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL hold_valid c%0d got %b exp 1", c, out_valid); end
            total++; if (out_data !== model(MSG0, 1)) begin bad++; $display("[TB] FAIL hold_data c%0d got %h exp %h", c, out_data, model(MSG0, 1)); end
            total++; if (out_id !== 1'b0) begin bad++; $display("[TB] FAIL hold_id c%0d got %b exp 0", c, out_id); end
            total++; if (req_ready !== 2'b00) begin bad++; $display("[TB] FAIL hold_no_grant c%0d got %b exp 00", c, req_ready); end
        end
        finish_out();
        #1;
        total++; if (req_ready !== 2'b10) begin bad++; $display("[TB] FAIL hold_next_grant got %b exp 10", req_ready); end
        pump(2'b10, -1, 0, -1, n, ok);
        total++; if (out_data !== model(MSG1, 1)) begin bad++; $display("[TB] FAIL hold_data1 got %h exp %h", out_data, model(MSG1, 1)); end
        total++; if (out_id !== 1'b1) begin bad++; $display("[TB] FAIL hold_id1 got %b exp 1", out_id); end
        finish_out();
    endtask

    task automatic test_mid_reset();
        int n;
        bit ok;
        key_mode = 1;
        req_valid = 2'b01;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("[TB] FAIL midrst_grant got %b exp 01", req_ready); end
        pump(2'b01, -1, 0, 9, n, ok);
        rst = 1'b1;
        #1;
        total++; if (key_ready !== 1'b0) begin bad++; $display("[TB] FAIL midrst_key_ready got %b exp 0", key_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_out_valid got %b exp 0", out_valid); end
        total++; if (out_data !== 240'h0) begin bad++; $display("[TB] FAIL midrst_out_data got %h exp 0", out_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy got %b exp 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        req_valid = 2'b11;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("[TB] FAIL midrst_ptr_restart got %b exp 01", req_ready); end
        pump(2'b01, -1, 0, -1, n, ok);
        total++; if (n !== 16) begin bad++; $display("[TB] FAIL midrst_latency got %0d exp 16", n); end
        total++; if (out_data !== model(MSG0, 1)) begin bad++; $display("[TB] FAIL midrst_data got %h exp %h", out_data, model(MSG0, 1)); end
        finish_out();
        #1;
        total++; if (req_ready !== 2'b10) begin bad++; $display("[TB] FAIL midrst_second_grant got %b exp 10", req_ready); end
        pump(2'b10, -1, 0, -1, n, ok);
        total++; if (out_id !== 1'b1) begin bad++; $display("[TB] FAIL midrst_id1 got %b exp 1", out_id); end
        finish_out();
    endtask

`ifdef OTP_KEY_USAGE_CNT_EN
    task automatic test_key_used();
        int n;
        bit ok;
        do_reset();
        total++; if (key_used !== 32'd0) begin bad++; $display("[TB] FAIL used_reset got %0d exp 0", key_used); end
        key_mode = 1;
        req_valid = 2'b01;
        pump(2'b01, 7, 3, -1, n, ok);
        finish_out();
        req_valid = 2'b10;
        pump(2'b10, -1, 0, -1, n, ok);
        finish_out();
        total++; if (key_used !== 32'd30) begin bad++; $display("[TB] FAIL used_count got %0d exp 30", key_used); end
        force dut.key_used_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.key_used_cnt;
        req_valid = 2'b01;
        pump(2'b01, -1, 0, 3, n, ok);
        total++; if (key_used !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL used_saturate got %h exp ffffffff", key_used); end
        do_reset();
    endtask
`endif

    initial begin
        $display("[TB] starting otp_cypher_sched bench");
        test_reset();
        test_single();
        test_two_req();
        test_key_stall();
        test_out_hold();
        test_mid_reset();
`ifdef OTP_KEY_USAGE_CNT_EN
        test_key_used();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
